// File: rtl/demux_pkg.sv
// demux_pkg: constants shared by the buffered 1:2 word demux.
//   DATA_W     - default data word width
//   FIFO_DEPTH - default entries per output FIFO (power of two, >= 2)
//   SEL_CH0/1  - in_select encoding for the two destination channels
package demux_pkg;

    localparam int   DATA_W     = 32;
    localparam int   FIFO_DEPTH = 2;

    localparam logic SEL_CH0    = 1'b0;
    localparam logic SEL_CH1    = 1'b1;

endpackage

// File: rtl/demux_chan_fifo.sv
// demux_chan_fifo: single-channel FIFO behind one demux output.
//   clk, rst_n - clock, asynchronous active-low reset
//   i_push     - write i_data (ignored while full)
//   i_data     - word to write
//   o_full     - occupancy == DEPTH
//   o_valid    - head valid (occupancy != 0)
//   i_ready    - consumer takes head (ignored while empty)
//   o_data     - head word, read combinationally from registered state
// No bypass: a word written at an edge is visible at o_data after that edge.
module demux_chan_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [PTR_W:0]              r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    // Full refuses a push even when a pop happens the same cycle.
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_ready & ~w_empty;

    assign o_full  = w_full;
    assign o_valid = ~w_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage is reset too so the head reads 0 right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/demux_32_bit_1_2_buffered.sv
// demux_32_bit_1_2_buffered: routes one valid/ready word stream to one of two
// buffered output channels chosen per word by in_select.
//   clk, rst_n                      - clock, asynchronous active-low reset
//   in_valid/in_ready/in_data       - producer handshake and word
//   in_select                       - 0 -> channel 0, 1 -> channel 1
//   out0_valid/out0_ready/out0_data - channel 0 consumer handshake
//   out1_valid/out1_ready/out1_data - channel 1 consumer handshake
//   cnt0, cnt1                      - words delivered per channel
// Optional feature macro: DEMUX_CNT_EN builds the delivery counters and the
// cnt0/cnt1 ports; without it they are absent.
module demux_32_bit_1_2_buffered
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = FIFO_DEPTH
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    logic w_full0;
    logic w_full1;
    logic w_push0;
    logic w_push1;
    logic w_accept;

    // Depends on in_select only, never on the consumer readies.
    assign in_ready = (in_select == SEL_CH1) ? ~w_full1 : ~w_full0;
    assign w_accept = in_valid & in_ready;
    assign w_push0  = w_accept & (in_select == SEL_CH0);
    assign w_push1  = w_accept & (in_select == SEL_CH1);

    demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push0),
        .i_data  (in_data),
        .o_full  (w_full0),
        .o_valid (out0_valid),
        .i_ready (out0_ready),
        .o_data  (out0_data)
    );

    demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push1),
        .i_data  (in_data),
        .o_full  (w_full1),
        .o_valid (out1_valid),
        .i_ready (out1_ready),
        .o_data  (out1_data)
    );

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Counts completed pops; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready) r_cnt0 <= r_cnt0 + CNT_W'(1);
            if (out1_valid && out1_ready) r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_demux_32_bit_1_2_buffered.sv
// Scoreboard bench: the stimulus pushes the hand-chosen expected word of each
// accepted transfer onto that channel's queue; a negedge monitor pops and
// compares whenever a channel completes a valid/ready handshake.
module tb_demux_32_bit_1_2_buffered;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_select;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out0_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out1_data;
`ifdef DEMUX_CNT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    int total = 0;
    int bad   = 0;
    int v0cnt = 0;
    int v1cnt = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    always #5 clk = ~clk;

    demux_32_bit_1_2_buffered dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_select  (in_select),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Present a word and hold it until accepted; record the expected word.
    task automatic push(input logic sel, input logic [31:0] d);
        bit ok = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_select = sel; in_data = d;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin ok = 1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL push_timeout: got in_ready=0 want 1 (sel %0d)", sel);
        end else if (sel) q1.push_back(d);
        else q0.push_back(d);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare every completed handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out0_valid) v0cnt++;
            if (out1_valid) v1cnt++;
            if (out0_valid && out0_ready) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ch0_extra: got %h want nothing", out0_data);
                end else check("ch0_data", out0_data, q0.pop_front());
            end
            if (out1_valid && out1_ready) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ch1_extra: got %h want nothing", out1_data);
                end else check("ch1_data", out1_data, q1.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_select = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_v0", {31'b0, out0_valid}, 32'd0);
        check("rst_v1", {31'b0, out1_valid}, 32'd0);
        check("rst_d0", out0_data, 32'd0);
        check("rst_d1", out1_data, 32'd0);
        in_select = 1'b0; #1 check("rst_rdy0", {31'b0, in_ready}, 32'd1);
        in_select = 1'b1; #1 check("rst_rdy1", {31'b0, in_ready}, 32'd1);
`ifdef DEMUX_CNT_EN
        check("rst_cnt0", {16'b0, cnt0}, 32'd0);
        check("rst_cnt1", {16'b0, cnt1}, 32'd0);
`endif

        // Steering
        v0cnt = 0; v1cnt = 0;
        push(1'b0, 32'hDEADBEEF);
        push(1'b1, 32'h12345678);
        repeat (4) @(negedge clk);
        check("steer_v0_cycles", v0cnt, 32'd1);
        check("steer_v1_cycles", v1cnt, 32'd1);

        // Fill and block
        @(posedge clk); #1 out0_ready = 1'b0;
        push(1'b0, 32'h1);
        push(1'b0, 32'h2);
        @(posedge clk); #1;
        in_valid = 1'b1; in_select = 1'b0; in_data = 32'h3;
        @(negedge clk);
        check("full_rdy0", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0; in_select = 1'b1;
        #1 check("full_rdy1", {31'b0, in_ready}, 32'd1);
        in_select = 1'b0;
        push(1'b1, 32'hA);
        repeat (2) @(negedge clk);
        check("hold_v0", {31'b0, out0_valid}, 32'd1);
        check("hold_d0", out0_data, 32'h1);
        check("hold_q1_empty", q1.size(), 32'd0);

        // Drain and order
        @(posedge clk); #1 out0_ready = 1'b1; in_select = 1'b0;
        @(negedge clk);
        check("drain_rdy0_first", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        check("drain_rdy0_after", {31'b0, in_ready}, 32'd1);
        check("drain_d0_second", out0_data, 32'h2);
        @(negedge clk);
        check("drain_v0_done", {31'b0, out0_valid}, 32'd0);

        // Wrap and concurrency
        fork
            begin
                for (int i = 0; i < 10; i++) push(1'b1, 32'h100 + i);
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk); #1 out1_ready = ~out1_ready;
                end
            end
        join
        @(posedge clk); #1 out1_ready = 1'b1;
        for (int n = 0; n < 30 && q1.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        check("wrap_q1_drained", q1.size(), 32'd0);
        check("wrap_v1_idle", {31'b0, out1_valid}, 32'd0);
`ifdef DEMUX_CNT_EN
        check("cnt0_total", {16'b0, cnt0}, 32'd3);
        check("cnt1_total", {16'b0, cnt1}, 32'd12);
`endif

        // Asynchronous reset mid-stream
        @(posedge clk); #1 out0_ready = 1'b0; out1_ready = 1'b0;
        push(1'b0, 32'h55);
        push(1'b1, 32'h66);
        @(negedge clk);
        check("pre_rst_v0", {31'b0, out0_valid}, 32'd1);
        check("pre_rst_v1", {31'b0, out1_valid}, 32'd1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("async_v0", {31'b0, out0_valid}, 32'd0);
        check("async_v1", {31'b0, out1_valid}, 32'd0);
        check("async_d0", out0_data, 32'd0);
        q0.delete(); q1.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out0_ready = 1'b1; out1_ready = 1'b1;
        @(negedge clk);
        check("post_rst_v0", {31'b0, out0_valid}, 32'd0);
        check("post_rst_v1", {31'b0, out1_valid}, 32'd0);
`ifdef DEMUX_CNT_EN
        check("post_rst_cnt0", {16'b0, cnt0}, 32'd0);
        check("post_rst_cnt1", {16'b0, cnt1}, 32'd0);
`endif
        check("end_q0_empty", q0.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
